// File: rtl/mem_store_unit.sv
// mem_store_unit: write-side store path for the multi-cycle CPU.
// Captures one sb/sh/sw request, checks alignment, replicates lanes and runs a req/ack memory write.
module mem_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          iStart,
  input  logic [1:0]    iSize,
  input  logic [AW-1:0] iAddr,
  input  logic [31:0]   iData,
  input  logic          iMemAck,
  output logic [AW-1:0] oMemAddr,
  output logic [31:0]   oMemData,
  output logic [3:0]    oMemBe,
  output logic          oMemWe,
  output logic          oBusy,
  output logic          oDone,
  output logic          oErr
);

  // Wait counter only has to hold 0..TIMEOUT-1; reaching the last value without ack aborts.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [AW-1:0]   addr_r;
  logic [1:0]      size_r;
  logic [31:0]     data_r;
  logic            bad_s;
  logic            err_s;
  logic            load_s;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      SZ_BYTE: w = {4{d[7:0]}};
      SZ_HALF: w = {2{d[15:0]}};
      SZ_WORD: w = d;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  // Next-state, wait counter and completion status.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    err_s   = 1'b0;
    bad_s   = misaligned(size_r, addr_r[1:0]);
    load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_s = CNT_ZERO;
        if (iStart) begin
          state_s = S_CHECK;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CHECK: begin
        if (bad_s) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else begin
          load_s  = 1'b1;
          state_s = S_WRITE;
        end
      end
      S_WRITE: begin
        // An ack in the final counted cycle still completes cleanly.
        if (iMemAck) begin
          state_s = S_DONE;
        end else if (cnt_r == CNT_LAST) begin
          err_s   = 1'b1;
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      S_DONE: begin
        cnt_s   = CNT_ZERO;
        state_s = S_IDLE;
      end
      default: begin
        cnt_s   = CNT_ZERO;
        state_s = S_IDLE;
      end
    endcase
  end

  // State and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Request capture; only an accepted start updates the held request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r <= {AW{1'b0}};
      size_r <= 2'b00;
      data_r <= 32'h0000_0000;
    end else if (state_r == S_IDLE && iStart) begin
      addr_r <= iAddr;
      size_r <= iSize;
      data_r <= iData;
    end
  end

  // Registered outputs, driven from the state being entered so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oMemAddr <= {AW{1'b0}};
      oMemData <= 32'h0000_0000;
      oMemBe   <= 4'b0000;
      oMemWe   <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
      oErr     <= 1'b0;
    end else begin
      oBusy  <= (state_s != S_IDLE);
      oMemWe <= (state_s == S_WRITE);
      oDone  <= (state_s == S_DONE);
      oErr   <= (state_s == S_DONE) && err_s;
      if (load_s) begin
        oMemAddr <= {addr_r[AW-1:2], 2'b00};
        oMemData <= lane_data(size_r, data_r);
        oMemBe   <= lane_be(size_r, addr_r[1:0]);
      end else if (state_s != S_WRITE) begin
        oMemBe <= 4'b0000;
      end
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Randomized self-checking bench for mem_store_unit: a transaction-level model expands each
// accepted request into the per-cycle outputs it must produce, and a compare loop checks every cycle.
module tb_mem_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iStart, iMemAck;
  logic [1:0]  iSize;
  logic [31:0] iAddr, iData;
  logic [31:0] oMemAddr, oMemData;
  logic [3:0]  oMemBe;
  logic        oMemWe, oBusy, oDone, oErr;

  mem_store_unit #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst(rst), .iStart(iStart), .iSize(iSize), .iAddr(iAddr), .iData(iData),
    .iMemAck(iMemAck), .oMemAddr(oMemAddr), .oMemData(oMemData), .oMemBe(oMemBe),
    .oMemWe(oMemWe), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        busy;
    logic        we;
    logic        done;
    logic        err;
    logic [3:0]  be;
    logic        chk;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        expq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          we_cnt = 0;
  logic        last_err = 1'b0;
  logic [31:0] last_waddr = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [3:0]  last_wbe = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Store semantics: lane n carries source byte (n mod width); enables cover [a, a+width).
  function automatic void model_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dt,
                                      output logic err, output logic [3:0] be, output logic [31:0] wd);
    int nb;
    int a;
    a  = int'(ad[1:0]);
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % nb) != 0);
    be = 4'h0;
    wd = 32'h0;
    if (!err) begin
      for (int n = 0; n < 4; n++) begin
        wd[8*n +: 8] = dt[8*(n % nb) +: 8];
        if (n >= a && n < a + nb) be[n] = 1'b1;
      end
    end
  endfunction

  // Expand one accepted request into its expected output cycles; waits >= TO means no ack.
  function automatic void push_expected(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dt,
                                        input int waits);
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    int          nw;
    model_store(sz, ad, dt, err, be, wd);
    expq.push_back('{busy:1'b1, we:1'b0, done:1'b0, err:1'b0, be:4'h0, chk:1'b0, addr:32'h0, data:32'h0});
    if (err) begin
      expq.push_back('{busy:1'b1, we:1'b0, done:1'b1, err:1'b1, be:4'h0, chk:1'b0, addr:32'h0, data:32'h0});
    end else begin
      nw = (waits < TO) ? waits + 1 : TO;
      for (int j = 0; j < nw; j++)
        expq.push_back('{busy:1'b1, we:1'b1, done:1'b0, err:1'b0, be:be, chk:1'b1,
                         addr:{ad[31:2], 2'b00}, data:wd});
      expq.push_back('{busy:1'b1, we:1'b0, done:1'b1, err:(waits >= TO), be:4'h0, chk:1'b0,
                       addr:32'h0, data:32'h0});
    end
  endfunction

  // Issue one request from an IDLE cycle (called #1 after a rising edge); returns in the next IDLE cycle.
  task automatic do_txn(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dt,
                        input int waits, input bit stray);
    logic        err;
    logic [3:0]  be;
    logic [31:0] wd;
    int          nw;
    int          ack_at;
    model_store(sz, ad, dt, err, be, wd);
    iStart = 1'b1; iSize = sz; iAddr = ad; iData = dt;
    @(posedge clk);
    push_expected(sz, ad, dt, waits);
    #1;
    iStart = 1'b0; iSize = 2'($urandom); iAddr = $urandom; iData = $urandom;
    iMemAck = stray ? 1'($urandom) : 1'b0;
    if (!err) begin
      nw = (waits < TO) ? waits + 1 : TO;
      ack_at = (waits < TO) ? waits + 1 : 0;
      @(posedge clk); #1;
      for (int j = 1; j <= nw; j++) begin
        iMemAck = (j == ack_at);
        iStart = stray ? 1'($urandom) : 1'b0;
        @(posedge clk); #1;
      end
    end else begin
      @(posedge clk); #1;
    end
    iMemAck = stray ? 1'($urandom) : 1'b0;
    iStart = stray ? 1'($urandom) : 1'b0;
    @(posedge clk); #1;
    iMemAck = 1'b0;
    iStart = 1'b0;
  endtask

  task automatic idle_gap(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      iMemAck = stray_ack ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    iMemAck = 1'b0;
  endtask

  task automatic run_pin(input string nm, input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] dt,
                         input int waits, input int exp_lat, input int exp_we, input logic exp_err);
    int s;
    int w0;
    s = cyc;
    w0 = we_cnt;
    do_txn(sz, ad, dt, waits, 1'b0);
    check({nm, "_lat"}, 64'(last_done_cyc - s), 64'(exp_lat));
    check({nm, "_wecyc"}, 64'(we_cnt - w0), 64'(exp_we));
    check({nm, "_err"}, {63'h0, last_err}, {63'h0, exp_err});
  endtask

  initial begin
    logic        m_err;
    logic [3:0]  m_be;
    logic [31:0] m_d;
    int          waits;
    iStart = 1'b0; iSize = 2'b00; iAddr = 32'h0; iData = 32'h0; iMemAck = 1'b0;

    fork
      forever begin : cmp
        exp_t e;
        @(negedge clk);
        if (rst) begin
          expq.delete();
        end else begin
          if (expq.size() > 0) e = expq.pop_front();
          else e = '{busy:1'b0, we:1'b0, done:1'b0, err:1'b0, be:4'h0, chk:1'b0, addr:32'h0, data:32'h0};
          check("ctrl", {56'h0, oBusy, oMemWe, oDone, oErr, oMemBe}, {56'h0, e.busy, e.we, e.done, e.err, e.be});
          if (e.chk) begin
            check("addr", {32'h0, oMemAddr}, {32'h0, e.addr});
            check("data", {32'h0, oMemData}, {32'h0, e.data});
          end
          if (oDone === 1'b1) begin last_done_cyc = cyc; last_err = oErr; end
          if (oMemWe === 1'b1) begin
            we_cnt++;
            last_waddr = oMemAddr; last_wdata = oMemData; last_wbe = oMemBe;
          end
        end
      end
    join_none

    #12;
    check("rst_mem", {oMemAddr, oMemData}, 64'h0);
    check("rst_ctl", {56'h0, oMemBe, oMemWe, oBusy, oDone, oErr}, 64'h0);

    // Pin the model against hand-worked lane patterns.
    model_store(2'b00, 32'h203, 32'h0000_00A5, m_err, m_be, m_d);
    check("m_sb", {27'h0, m_err, m_be, m_d}, {27'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5});
    model_store(2'b01, 32'h202, 32'h0000_1234, m_err, m_be, m_d);
    check("m_sh", {27'h0, m_err, m_be, m_d}, {27'h0, 1'b0, 4'b1100, 32'h1234_1234});
    model_store(2'b10, 32'h100, 32'hDEAD_BEEF, m_err, m_be, m_d);
    check("m_sw", {27'h0, m_err, m_be, m_d}, {27'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF});
    model_store(2'b01, 32'h101, 32'h0, m_err, m_be, m_d);
    check("m_sh_mis", {63'h0, m_err}, {63'h0, 1'b1});
    model_store(2'b10, 32'h102, 32'h0, m_err, m_be, m_d);
    check("m_sw_mis", {63'h0, m_err}, {63'h0, 1'b1});

    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_pin("sw", 2'b10, 32'h100, 32'hDEAD_BEEF, 0, 3, 1, 1'b0);
    check("sw_addr", {32'h0, last_waddr}, {32'h0, 32'h0000_0100});
    check("sw_data", {32'h0, last_wdata}, {32'h0, 32'hDEAD_BEEF});
    check("sw_be", {60'h0, last_wbe}, {60'h0, 4'b1111});
    run_pin("sb", 2'b00, 32'h203, 32'h0000_00A5, 2, 5, 3, 1'b0);
    check("sb_addr", {32'h0, last_waddr}, {32'h0, 32'h0000_0200});
    check("sb_data", {32'h0, last_wdata}, {32'h0, 32'hA5A5_A5A5});
    check("sb_be", {60'h0, last_wbe}, {60'h0, 4'b1000});
    run_pin("sh", 2'b01, 32'h202, 32'h0000_1234, 0, 3, 1, 1'b0);
    check("sh_data", {32'h0, last_wdata}, {32'h0, 32'h1234_1234});
    check("sh_be", {60'h0, last_wbe}, {60'h0, 4'b1100});
    run_pin("sh_mis", 2'b01, 32'h101, 32'h0, 0, 2, 0, 1'b1);
    run_pin("sw_mis", 2'b10, 32'h102, 32'h0, 0, 2, 0, 1'b1);
    run_pin("sz_bad", 2'b11, 32'h100, 32'h0, 0, 2, 0, 1'b1);
    run_pin("tmo", 2'b10, 32'h400, 32'h1111_2222, TO, TO + 2, TO, 1'b1);
    run_pin("ack_last", 2'b10, 32'h400, 32'h3333_4444, TO - 1, TO + 2, TO, 1'b0);

    // Stray start during WRITE/DONE, stray acks while idle, then back-to-back requests.
    idle_gap(4, 1'b1);
    do_txn(2'b10, 32'h500, 32'hCAFE_F00D, 3, 1'b1);
    do_txn(2'b00, 32'h501, 32'h0000_0077, 0, 1'b1);
    do_txn(2'b01, 32'h600, 32'h0000_ABCD, 1, 1'b0);
    idle_gap(3, 1'b1);

    // Reset in the middle of a write that is never acknowledged.
    iStart = 1'b1; iSize = 2'b10; iAddr = 32'h300; iData = 32'h55;
    @(posedge clk);
    push_expected(2'b10, 32'h300, 32'h55, TO);
    #1 iStart = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rstw_mem", {oMemAddr, oMemData}, 64'h0);
    check("rstw_ctl", {56'h0, oMemBe, oMemWe, oBusy, oDone, oErr}, 64'h0);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    idle_gap(3, 1'b0);

    for (int t = 0; t < 40; t++) begin
      case ($urandom % 6)
        0: waits = 0;
        1: waits = 1;
        2: waits = int'($urandom % 5);
        3: waits = TO - 1;
        4: waits = TO;
        default: waits = 2;
      endcase
      do_txn(2'($urandom), $urandom, $urandom, waits, 1'($urandom));
      idle_gap(int'($urandom % 3), 1'($urandom));
    end
    idle_gap(2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
